pipe_exe_muldiv: RTL and testbench
==================================

// Module: pipe_exe_muldiv
// PURPOSE
//   Iterative multiply/divide unit in the EX stage, directly downstream of the ID/EX register.
//   Executes MULT/MULTU/DIV/DIVU on operands ea/eb and owns the HI/LO registers.
//   Asserts busy to the hazard unit, which drives wpcir low so that MFHI/MFLO and later
//   mul/div instructions stall until the operation completes.
// PARAMETERS
//   W      32  operand width; HI and LO are each W bits
//   CNT_W  6   iteration counter width; must satisfy 2**CNT_W > W
// PORTS
//   clock   in   1  rising-edge clock
//   resetn  in   1  asynchronous, active-low reset
//   estart  in   1  valid operation in EX; already qualified upstream (zero when flushed or stalled)
//   eop     in   3  0 NOP, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 reserved (treated as NOP)
//   ea      in   W  rs operand: multiplicand / dividend / MTHI-MTLO data
//   eb      in   W  rt operand: multiplier / divisor
//   hi      out  W  HI register
//   lo      out  W  LO register
//   busy    out  1  high whenever state != IDLE
//   done    out  1  one-cycle pulse in the cycle after HI/LO receive a mul/div result
// BEHAVIOUR
//   - Reset (async, any state, including mid-operation): state=IDLE, hi=0, lo=0, busy=0, done=0,
//     counter and all working registers cleared. In-flight result discarded.
//   - FSM states: IDLE -> RUN -> FIX -> IDLE.
//   - IDLE: estart sampled at rising edge k.
//       eop 5/6: hi/lo <= ea at edge k; stay IDLE; done stays 0.
//       eop 1-4: latch operand magnitudes (signed ops) or raw values (unsigned ops),
//                latch result signs, clear counter, go to RUN.
//       eop 0/7, or estart=0: no action.
//   - RUN: one radix-2 step per cycle; counter increments; leave after W steps
//     (edges k+1 .. k+W), then go to FIX.
//       Multiply: shift-add into a 2W-bit product.
//       Divide: restoring; W-bit partial remainder with W+1-bit trial subtract.
//   - FIX (edge k+W+1): apply sign correction and write {hi,lo}; return to IDLE.
//       busy is high for exactly W+1 cycles. done is high in the cycle after edge k+W+1.
//   - estart while busy: ignored entirely (no HI/LO write, no restart). The hazard unit
//     guarantees this does not occur in normal flow.
//   - Arithmetic rules:
//       MULT: 2W-bit two's-complement product, hi = upper W bits, lo = lower W bits.
//       MULTU: unsigned product, same split.
//       DIV/DIVU: lo = quotient, hi = remainder. Quotient truncates toward zero;
//                 remainder takes the sign of the dividend.
//       Divisor zero (DIV or DIVU): lo = all ones, hi = ea unchanged, no sign correction;
//                                   still takes W+1 cycles.
//       DIV overflow (-2^(W-1) / -1): lo = 0x80000000, hi = 0; no exception.
//   - eop and operands are latched at acceptance. Changes on ea/eb/eop during RUN have no effect.
// CONFIGURATION
//   MULDIV_EARLY_OUT_EN defined:
//       For MULT/MULTU, RUN exits to FIX at the first edge where the remaining
//       multiplier bits are all zero (minimum 1 step); busy = steps + 1 cycles.
//       Divide timing is unchanged.
//   MULDIV_EARLY_OUT_EN undefined:
//       Every mul/div takes exactly W RUN steps; latency is fixed at W+1 busy cycles.
// TESTING (W=32, macro undefined unless noted)
//   1. MULT ea=0xFFFFFFFD (-3), eb=7 -> busy 33 cycles; hi=0xFFFFFFFF, lo=0xFFFFFFEB; one done pulse.
//   2. MULTU ea=0xFFFFFFFF, eb=2 -> hi=0x00000001, lo=0xFFFFFFFE.
//   3. DIVU 100/7 -> lo=14, hi=2.
//      DIV -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
//      DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
//   4. DIV ea=0x12345678, eb=0 -> lo=0xFFFFFFFF, hi=0x12345678; busy 33 cycles.
//   5. MTHI 0xA5A5A5A5 -> hi updated at the same edge, busy stays 0.
//      Then start MULT; pulse estart with MTLO at cycle 5 of RUN -> ignored, lo = product only.
//   6. Start DIVU, drop resetn at cycle 10 of RUN -> hi=lo=0, busy=0 immediately, no done.
//      With MULDIV_EARLY_OUT_EN: MULTU 5*3 -> busy 3 cycles, lo=15.

Source files
------------

// File: rtl/pipe_exe_muldiv_if.sv
// pipe_exe_muldiv_if: operation and result bundle for the EX-stage mul/div unit.
//   master (ID/EX + hazard side): drives estart, eop, ea, eb; observes hi, lo, busy, done
//   slave  (pipe_exe_muldiv)     : consumes the operation; owns hi, lo, busy, done
interface pipe_exe_muldiv_if #(
    parameter int W = 32
);
    logic         estart;
    logic [2:0]   eop;
    logic [W-1:0] ea;
    logic [W-1:0] eb;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         busy;
    logic         done;

    modport master (output estart, eop, ea, eb, input hi, lo, busy, done);
    modport slave  (input estart, eop, ea, eb, output hi, lo, busy, done);
endinterface

// File: rtl/pipe_exe_muldiv.sv
// pipe_exe_muldiv: iterative radix-2 multiply/divide unit owning the HI/LO registers.
//   clock       rising-edge clock
//   resetn      asynchronous active-low reset
//   bus.estart  qualified operation valid
//   bus.eop     0 NOP, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 NOP
//   bus.ea/eb   operands (rs / rt)
//   bus.hi/lo   HI / LO registers
//   bus.busy    high while an operation is in flight
//   bus.done    one-cycle pulse after HI/LO take a mul/div result
// Optional build macro MULDIV_EARLY_OUT_EN: multiplies leave RUN once the
// remaining multiplier bits are all zero (divide timing is unaffected).
//
// state | meaning
// IDLE  | waiting for estart; MTHI/MTLO write here
// RUN   | one shift-add / restoring-subtract step per cycle
// FIX   | sign correction and HI/LO write
module pipe_exe_muldiv #(
    parameter int W     = 32,
    parameter int CNT_W = 6
) (
    input  logic               clock,
    input  logic               resetn,
    pipe_exe_muldiv_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             is_div;
    logic             neg_q;
    logic             neg_r;
    logic             div_zero;
    logic [2*W-1:0]   acc;
    logic [2*W-1:0]   mcand;
    logic [W-1:0]     opb;      // multiplier (shifts right) or divisor (static)
    logic [W-1:0]     quo;      // dividend bits shift out, quotient bits shift in
    logic [W-1:0]     rem;

    logic             op_signed;
    logic             op_muldiv;
    logic             a_neg;
    logic             b_neg;
    logic [W-1:0]     a_mag;
    logic [W-1:0]     b_mag;
    logic [W:0]       shifted;
    logic             q_bit;
    logic [W-1:0]     diff;
    logic             last_step;
    logic [2*W-1:0]   prod_fix;
    logic [W-1:0]     q_fix;
    logic [W-1:0]     r_fix;

    always_comb begin
        op_signed = (bus.eop == 3'd1) || (bus.eop == 3'd3);
        op_muldiv = (bus.eop >= 3'd1) && (bus.eop <= 3'd4);
        a_neg     = op_signed && bus.ea[W-1];
        b_neg     = op_signed && bus.eb[W-1];
        a_mag     = a_neg ? -bus.ea : bus.ea;
        b_mag     = b_neg ? -bus.eb : bus.eb;
    end

    // Partial remainder stays below the divisor, so a W-bit difference is exact
    // whenever the trial subtract succeeds.
    always_comb begin
        shifted = {rem, quo[W-1]};
        q_bit   = shifted >= {1'b0, opb};
        diff    = shifted[W-1:0] - opb;
    end

`ifdef MULDIV_EARLY_OUT_EN
    always_comb last_step = (cnt == CNT_W'(W-1)) || (!is_div && (opb[W-1:1] == '0));
`else
    always_comb last_step = (cnt == CNT_W'(W-1));
`endif

    // With a zero divisor every trial succeeds and rem ends up holding the
    // dividend magnitude, so the sign-corrected remainder is exactly ea.
    always_comb begin
        prod_fix = neg_q ? -acc : acc;
        q_fix    = neg_q ? -quo : quo;
        r_fix    = neg_r ? -rem : rem;
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state    <= IDLE;
            cnt      <= '0;
            is_div   <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            div_zero <= 1'b0;
            acc      <= '0;
            mcand    <= '0;
            opb      <= '0;
            quo      <= '0;
            rem      <= '0;
            bus.hi   <= '0;
            bus.lo   <= '0;
            bus.busy <= 1'b0;
            bus.done <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    bus.done <= 1'b0;
                    if (bus.estart) begin
                        if (bus.eop == 3'd5) begin
                            bus.hi <= bus.ea;
                        end else if (bus.eop == 3'd6) begin
                            bus.lo <= bus.ea;
                        end else if (op_muldiv) begin
                            is_div   <= bus.eop >= 3'd3;
                            neg_q    <= a_neg ^ b_neg;
                            neg_r    <= a_neg;
                            div_zero <= bus.eb == '0;
                            acc      <= '0;
                            mcand    <= {{W{1'b0}}, a_mag};
                            opb      <= b_mag;
                            quo      <= a_mag;
                            rem      <= '0;
                            cnt      <= '0;
                            bus.busy <= 1'b1;
                            state    <= RUN;
                        end
                    end
                end
                RUN: begin
                    cnt <= cnt + 1'b1;
                    if (is_div) begin
                        rem <= q_bit ? diff : shifted[W-1:0];
                        quo <= {quo[W-2:0], q_bit};
                    end else begin
                        if (opb[0]) begin
                            acc <= acc + mcand;
                        end
                        mcand <= mcand << 1;
                        opb   <= opb >> 1;
                    end
                    if (last_step) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    if (is_div) begin
                        bus.lo <= div_zero ? '1 : q_fix;
                        bus.hi <= r_fix;
                    end else begin
                        {bus.hi, bus.lo} <= prod_fix;
                    end
                    bus.busy <= 1'b0;
                    bus.done <= 1'b1;
                    state    <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_pipe_exe_muldiv.sv
// tb_pipe_exe_muldiv: directed and randomized checks of pipe_exe_muldiv against
// an arithmetic reference model (64-bit products, native division).
module tb_pipe_exe_muldiv;
    localparam int W = 32;

    logic clock = 1'b0;
    logic resetn = 1'b0;
    int   checks = 0;
    int   errors = 0;

    pipe_exe_muldiv_if #(.W(W)) bus ();

    pipe_exe_muldiv #(.W(W), .CNT_W(6)) dut (
        .clock  (clock),
        .resetn (resetn),
        .bus    (bus.slave)
    );

    always #5 clock = ~clock;

    function automatic void model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] h, output logic [31:0] l);
        longint          p;
        longint unsigned pu;
        int              sa;
        int              sb;
        h = '0;
        l = '0;
        sa = a;
        sb = b;
        case (op)
            3'd1: begin
                p = longint'(sa) * longint'(sb);
                {h, l} = p;
            end
            3'd2: begin
                pu = {32'b0, a} * {32'b0, b};
                {h, l} = pu;
            end
            3'd3: begin
                if (b == 0) begin
                    l = '1;
                    h = a;
                end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    l = 32'h8000_0000;
                    h = '0;
                end else begin
                    l = sa / sb;
                    h = sa % sb;
                end
            end
            3'd4: begin
                if (b == 0) begin
                    l = '1;
                    h = a;
                end else begin
                    l = a / b;
                    h = a % b;
                end
            end
            default: ;
        endcase
    endfunction

    function automatic int exp_busy(input logic [2:0] op, input logic [31:0] b);
        int          steps;
        logic [31:0] m;
        steps = W;
`ifdef MULDIV_EARLY_OUT_EN
        if (op == 3'd1 || op == 3'd2) begin
            m = (op == 3'd1 && b[31]) ? -b : b;
            steps = 1;
            for (int i = 0; i < 32; i++) if (m[i]) steps = i + 1;
        end
`else
        m = b;
        if (op == 3'd7 && m == 0) steps = W;
`endif
        return steps + 1;
    endfunction

    // Starts at a negedge, ends at a negedge after the done cycle.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] h, output logic [31:0] l,
                          output int busy_cyc, output int done_cnt, output bit timeout);
        bus.estart = 1'b1;
        bus.eop    = op;
        bus.ea     = a;
        bus.eb     = b;
        @(posedge clock);
        #1;
        bus.estart = 1'b0;
        bus.eop    = 3'($urandom);
        bus.ea     = $urandom;
        bus.eb     = $urandom;
        busy_cyc = 0;
        done_cnt = 0;
        timeout  = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clock);
            if (bus.done) done_cnt++;
            if (bus.busy) busy_cyc++;
            else begin
                timeout = 1'b0;
                break;
            end
        end
        @(negedge clock);
        if (bus.done) done_cnt++;
        h = bus.hi;
        l = bus.lo;
    endtask

    task automatic test_reset();
        bus.estart = 1'b0;
        bus.eop    = '0;
        bus.ea     = '0;
        bus.eb     = '0;
        resetn     = 1'b0;
        repeat (3) @(negedge clock);
        checks++;
        if (bus.hi !== '0 || bus.lo !== '0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            errors++;
            $display("FAIL reset hi=%h lo=%h busy=%b done=%b want all zero", bus.hi, bus.lo, bus.busy, bus.done);
        end
        resetn = 1'b1;
        @(negedge clock);
    endtask

    task automatic test_directed();
        logic [2:0]  ops [7] = '{3'd1, 3'd2, 3'd4, 3'd3, 3'd3, 3'd3, 3'd2};
        logic [31:0] as  [7] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd100, 32'hFFFF_FFF9, 32'h8000_0000, 32'h1234_5678, 32'd5};
        logic [31:0] bs  [7] = '{32'd7, 32'd2, 32'd7, 32'd2, 32'hFFFF_FFFF, 32'd0, 32'd3};
        logic [31:0] ehs [7] = '{32'hFFFF_FFFF, 32'd1, 32'd2, 32'hFFFF_FFFF, 32'd0, 32'h1234_5678, 32'd0};
        logic [31:0] els [7] = '{32'hFFFF_FFEB, 32'hFFFF_FFFE, 32'd14, 32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF, 32'd15};
        logic [31:0] h, l;
        int          bc, dc;
        bit          to;
        for (int i = 0; i < 7; i++) begin
            run_op(ops[i], as[i], bs[i], h, l, bc, dc, to);
            checks++;
            if (h !== ehs[i] || l !== els[i]) begin
                errors++;
                $display("FAIL directed[%0d] result hi=%h lo=%h want hi=%h lo=%h", i, h, l, ehs[i], els[i]);
            end
            checks++;
            if (to || bc != exp_busy(ops[i], bs[i]) || dc != 1) begin
                errors++;
                $display("FAIL directed[%0d] timing busy=%0d done=%0d timeout=%b want busy=%0d done=1",
                         i, bc, dc, to, exp_busy(ops[i], bs[i]));
            end
        end
    endtask

    task automatic test_mthi_mtlo();
        bus.estart = 1'b1;
        bus.eop    = 3'd5;
        bus.ea     = 32'hA5A5_A5A5;
        @(posedge clock);
        #1;
        bus.estart = 1'b0;
        checks++;
        if (bus.hi !== 32'hA5A5_A5A5 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL mthi hi=%h busy=%b want hi=a5a5a5a5 busy=0", bus.hi, bus.busy);
        end
        @(negedge clock);
        bus.estart = 1'b1;
        bus.eop    = 3'd6;
        bus.ea     = 32'h5A5A_0F0F;
        @(posedge clock);
        #1;
        bus.estart = 1'b0;
        checks++;
        if (bus.lo !== 32'h5A5A_0F0F || bus.hi !== 32'hA5A5_A5A5 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL mtlo lo=%h hi=%h busy=%b want lo=5a5a0f0f hi=a5a5a5a5 busy=0", bus.lo, bus.hi, bus.busy);
        end
        @(negedge clock);
        checks++;
        if (bus.done !== 1'b0) begin
            errors++;
            $display("FAIL mt_done done=%b want 0", bus.done);
        end
    endtask

    task automatic test_ignore_while_busy();
        int bc = 0;
        bit to = 1'b1;
        bus.estart = 1'b1;
        bus.eop    = 3'd1;
        bus.ea     = 32'd6;
        bus.eb     = 32'd7;
        @(posedge clock);
        #1;
        bus.estart = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clock);
            if (bus.busy) bc++;
            else begin
                to = 1'b0;
                break;
            end
            if (bc == 5) begin
                bus.estart = 1'b1;
                bus.eop    = 3'd6;
                bus.ea     = 32'hDEAD_BEEF;
            end else begin
                bus.estart = 1'b0;
            end
        end
        bus.estart = 1'b0;
        checks++;
        if (to || bus.lo !== 32'd42 || bus.hi !== 32'd0 || bc != exp_busy(3'd1, 32'd7)) begin
            errors++;
            $display("FAIL ignore_busy lo=%h hi=%h busy=%0d want lo=0000002a hi=0 busy=%0d",
                     bus.lo, bus.hi, bc, exp_busy(3'd1, 32'd7));
        end
        @(negedge clock);
    endtask

    task automatic test_reset_mid_op();
        int dc = 0;
        bus.estart = 1'b1;
        bus.eop    = 3'd5;
        bus.ea     = 32'h1111_2222;
        @(negedge clock);
        bus.estart = 1'b1;
        bus.eop    = 3'd4;
        bus.ea     = 32'd1000;
        bus.eb     = 32'd3;
        @(posedge clock);
        #1;
        bus.estart = 1'b0;
        repeat (10) @(negedge clock);
        resetn = 1'b0;
        #1;
        checks++;
        if (bus.hi !== '0 || bus.lo !== '0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid hi=%h lo=%h busy=%b want 0 0 0", bus.hi, bus.lo, bus.busy);
        end
        @(negedge clock);
        resetn = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (bus.done || bus.busy) dc++;
        end
        checks++;
        if (dc != 0 || bus.lo !== '0 || bus.hi !== '0) begin
            errors++;
            $display("FAIL reset_mid_after activity=%0d hi=%h lo=%h want no activity and zeros", dc, bus.hi, bus.lo);
        end
    endtask

    task automatic test_random();
        logic [2:0]  op;
        logic [31:0] a, b, h, l, eh, el;
        int          bc, dc;
        bit          to;
        for (int n = 0; n < 30; n++) begin
            op = 3'(1 + $urandom_range(0, 3));
            case ($urandom_range(0, 3))
                0: begin a = $urandom; b = $urandom; end
                1: begin a = $urandom_range(0, 300); b = $urandom_range(1, 20); end
                2: begin a = $urandom; b = 32'd0; end
                default: begin
                    a = ($urandom_range(0, 1) != 0) ? 32'h8000_0000 : 32'h7FFF_FFFF;
                    b = ($urandom_range(0, 1) != 0) ? 32'hFFFF_FFFF : 32'd1;
                end
            endcase
            model(op, a, b, eh, el);
            run_op(op, a, b, h, l, bc, dc, to);
            checks++;
            if (h !== eh || l !== el) begin
                errors++;
                $display("FAIL random[%0d] op=%0d a=%h b=%h got hi=%h lo=%h want hi=%h lo=%h",
                         n, op, a, b, h, l, eh, el);
            end
            checks++;
            if (to || bc != exp_busy(op, b) || dc != 1) begin
                errors++;
                $display("FAIL random_timing[%0d] op=%0d busy=%0d done=%0d want busy=%0d done=1",
                         n, op, bc, dc, exp_busy(op, b));
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_mthi_mtlo();
        test_ignore_while_busy();
        test_reset_mid_op();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
